// File: rtl/axi_cmd_arbiter.sv
// Round-robin arbiter that shares one single-beat AXI3 master port between
// NUM_REQ command requesters, one transaction in flight at a time.
module axi_cmd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 4,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                           CLK,
    input  logic                           RESETn,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*AXI_ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*AXI_DATA_W-1:0]  req_wdata,
    output logic                           rsp_valid,
    output logic [IDX_W-1:0]               rsp_idx,
    output logic [AXI_DATA_W-1:0]          rsp_rdata,
    output logic [1:0]                     rsp_resp,
    output logic                           rsp_id_err,
    output logic [AXI_ID_W-1:0]            AWID,
    output logic [AXI_ADDR_W-1:0]          AWADDR,
    output logic [3:0]                     AWLEN,
    output logic [2:0]                     AWSIZE,
    output logic [1:0]                     AWBURST,
    output logic                           AWVALID,
    input  logic                           AWREADY,
    output logic [AXI_ID_W-1:0]            WID,
    output logic [AXI_DATA_W-1:0]          WDATA,
    output logic [AXI_DATA_W/8-1:0]        WSTRB,
    output logic                           WLAST,
    output logic                           WVALID,
    input  logic                           WREADY,
    input  logic [AXI_ID_W-1:0]            BID,
    input  logic [1:0]                     BRESP,
    input  logic                           BVALID,
    output logic                           BREADY,
    output logic [AXI_ID_W-1:0]            ARID,
    output logic [AXI_ADDR_W-1:0]          ARADDR,
    output logic [3:0]                     ARLEN,
    output logic [2:0]                     ARSIZE,
    output logic [1:0]                     ARBURST,
    output logic                           ARVALID,
    input  logic                           ARREADY,
    input  logic [AXI_ID_W-1:0]            RID,
    input  logic [AXI_DATA_W-1:0]          RDATA,
    input  logic [1:0]                     RRESP,
    input  logic                           RLAST,
    input  logic                           RVALID,
    output logic                           RREADY,
    output logic [2:0]                     dbg_state
);

    // Handshakes: a transfer happens on a rising edge where VALID and READY
    // are both 1; VALID, once raised, holds with stable payload until then.
    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WR_ADDR_DATA = 3'd1,
        S_WR_RESP      = 3'd2,
        S_RD_ADDR      = 3'd3,
        S_RD_DATA      = 3'd4,
        S_RSP          = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_gnt;
    logic [IDX_W-1:0]        w_cand;
    logic                    w_found;
    logic                    w_accept;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_id_err;
    logic [AXI_ADDR_W-1:0]   r_addr;
    logic [AXI_DATA_W-1:0]   r_wdata;
    logic [AXI_DATA_W-1:0]   r_rdata;
    logic [1:0]              r_resp;
    logic [AXI_ID_W-1:0]     w_id;
    logic [AXI_ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
    logic [AXI_DATA_W-1:0]   w_wdata_arr [NUM_REQ];
    logic                    w_unused;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = req_addr[gi*AXI_ADDR_W +: AXI_ADDR_W];
        assign w_wdata_arr[gi] = req_wdata[gi*AXI_DATA_W +: AXI_DATA_W];
    end

    // RLAST carries no information for single-beat reads.
    assign w_unused = RLAST;
    assign w_id     = AXI_ID_W'(r_idx);
    assign w_accept = (r_state == S_IDLE) && w_found;
    assign w_aw_hs  = AWVALID && AWREADY;
    assign w_w_hs   = WVALID && WREADY;

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = req_write[w_gnt] ? S_WR_ADDR_DATA : S_RD_ADDR;
                end
            end
            S_WR_ADDR_DATA: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_next = S_WR_RESP;
                end
            end
            S_WR_RESP: if (BVALID)  w_next = S_RSP;
            S_RD_ADDR: if (ARREADY) w_next = S_RD_DATA;
            S_RD_DATA: if (RVALID)  w_next = S_RSP;
            S_RSP:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        AWVALID    = 1'b0;
        WVALID     = 1'b0;
        BREADY     = 1'b0;
        ARVALID    = 1'b0;
        RREADY     = 1'b0;
        rsp_valid  = 1'b0;
        rsp_idx    = '0;
        rsp_rdata  = '0;
        rsp_resp   = '0;
        rsp_id_err = 1'b0;
        AWID       = w_id;
        AWADDR     = r_addr;
        AWLEN      = 4'd0;
        AWSIZE     = 3'b010;
        AWBURST    = 2'b01;
        WID        = w_id;
        WDATA      = r_wdata;
        WSTRB      = '1;
        WLAST      = 1'b1;
        ARID       = w_id;
        ARADDR     = r_addr;
        ARLEN      = 4'd0;
        ARSIZE     = 3'b010;
        ARBURST    = 2'b01;
        dbg_state  = r_state;
        case (r_state)
            S_IDLE:         if (w_found) req_ready[w_gnt] = 1'b1;
            S_WR_ADDR_DATA: begin
                AWVALID = !r_aw_done;
                WVALID  = !r_w_done;
            end
            S_WR_RESP:      BREADY  = 1'b1;
            S_RD_ADDR:      ARVALID = 1'b1;
            S_RD_DATA:      RREADY  = 1'b1;
            S_RSP: begin
                rsp_valid  = 1'b1;
                rsp_idx    = r_idx;
                rsp_rdata  = r_rdata;
                rsp_resp   = r_resp;
                rsp_id_err = r_id_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_ptr     <= '0;
            r_idx     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_resp    <= '0;
            r_id_err  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx     <= w_gnt;
                r_addr    <= w_addr_arr[w_gnt];
                r_wdata   <= w_wdata_arr[w_gnt];
                r_ptr     <= IDX_W'((int'(w_gnt) + 1) % NUM_REQ);
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (r_state == S_WR_ADDR_DATA) begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
            if (r_state == S_WR_RESP && BVALID) begin
                r_resp   <= BRESP;
                r_rdata  <= '0;
                r_id_err <= (BID != w_id);
            end
            if (r_state == S_RD_DATA && RVALID) begin
                r_resp   <= RRESP;
                r_rdata  <= RDATA;
                r_id_err <= (RID != w_id);
            end
        end
    end

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Self-checking bench for axi_cmd_arbiter: directed scenarios followed by
// randomized traffic, checked against a round-robin model and an expected queue.
module tb_axi_cmd_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int IW      = 4;
    localparam int XW      = 2;
    localparam int RSP_W   = XW + DW + 2 + 1;

    logic                  CLK = 1'b0;
    logic                  RESETn = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_write = '0;
    logic [NUM_REQ*AW-1:0] req_addr = '0;
    logic [NUM_REQ*DW-1:0] req_wdata = '0;
    logic                  rsp_valid;
    logic [XW-1:0]         rsp_idx;
    logic [DW-1:0]         rsp_rdata;
    logic [1:0]            rsp_resp;
    logic                  rsp_id_err;
    logic [IW-1:0]         AWID, WID, ARID;
    logic [AW-1:0]         AWADDR, ARADDR;
    logic [3:0]            AWLEN, ARLEN;
    logic [2:0]            AWSIZE, ARSIZE;
    logic [1:0]            AWBURST, ARBURST;
    logic                  AWVALID, WVALID, ARVALID, BREADY, RREADY;
    logic [DW-1:0]         WDATA;
    logic [DW/8-1:0]       WSTRB;
    logic                  WLAST;
    logic                  AWREADY = 1'b0, WREADY = 1'b0, ARREADY = 1'b0;
    logic [IW-1:0]         BID = '0, RID = '0;
    logic [1:0]            BRESP = '0, RRESP = '0;
    logic                  BVALID = 1'b0, RVALID = 1'b0, RLAST = 1'b0;
    logic [DW-1:0]         RDATA = '0;
    logic [2:0]            dbg_state;

    int checks = 0;
    int failures = 0;
    int model_ptr = 0;
    logic [RSP_W-1:0] exp_q[$];

    int            s_aw_dly = 0, s_w_dly = 0, s_ar_dly = 0, s_b_dly = 0, s_r_dly = 0;
    logic [1:0]    s_resp = '0;
    logic [DW-1:0] s_rdata = '0;
    bit            s_id_ovr = 1'b0;
    logic [IW-1:0] s_id_val = '0;

    axi_cmd_arbiter #(
        .NUM_REQ(NUM_REQ), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW)
    ) dut (
        .CLK(CLK), .RESETn(RESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_idx(rsp_idx), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_id_err(rsp_id_err),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference grant: first valid requester from ptr upward, wrapping.
    function automatic int model_grant(input logic [NUM_REQ-1:0] mask, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]            = w;
        req_addr[i*AW +: AW]    = a;
        req_wdata[i*DW +: DW]   = d;
    endtask

    task automatic slave_quiet();
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        ARREADY = 1'b0;
        BVALID  = 1'b0;
        RVALID  = 1'b0;
        RLAST   = 1'b0;
    endtask

    task automatic slave_defaults();
        s_aw_dly = 0; s_w_dly = 0; s_ar_dly = 0; s_b_dly = 0; s_r_dly = 0;
        s_resp = 2'b00; s_rdata = '0; s_id_ovr = 1'b0; s_id_val = '0;
    endtask

    // Called in an IDLE cycle with req_valid already set; runs one complete
    // transaction acting as the AXI slave, returns in the following IDLE cycle.
    task automatic serve_one(input string tag);
        int g, cyc, aw_n, w_n, ar_n, b_n, r_n, exp_lat;
        logic w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [IW-1:0] rid;
        logic [XW-1:0] gx;
        logic [RSP_W-1:0] e, got;
        bit done;
        #1;
        g = model_grant(req_valid, model_ptr);
        if (g < 0) g = 0;
        gx = XW'(g);
        chk({tag, "_req_ready"}, req_ready, 64'(1) << g);
        chk({tag, "_idle_quiet"}, {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 0);
        w = req_write[g];
        a = req_addr[g*AW +: AW];
        d = req_wdata[g*DW +: DW];
        model_ptr = (g + 1) % NUM_REQ;
        rid = s_id_ovr ? s_id_val : IW'(g);
        e = {gx, (w ? {DW{1'b0}} : s_rdata), s_resp, (rid != IW'(g))};
        exp_q.push_back(e);
        exp_lat = w ? (((s_aw_dly > s_w_dly) ? s_aw_dly : s_w_dly) + s_b_dly + 3)
                    : (s_ar_dly + s_r_dly + 3);
        aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 60) begin
            step();
            cyc++;
            slave_quiet();
            if (cyc == 1) begin
                if (w) chk({tag, "_aw_w_rise"}, {AWVALID, WVALID, ARVALID}, 3'b110);
                else   chk({tag, "_ar_rise"}, {AWVALID, WVALID, ARVALID}, 3'b001);
            end
            chk({tag, "_busy_no_ready"}, req_ready, 0);
            if (AWVALID) begin
                chk({tag, "_awaddr"}, AWADDR, a);
                chk({tag, "_awid"}, AWID, IW'(g));
                chk({tag, "_aw_const"}, {AWLEN, AWSIZE, AWBURST}, {4'd0, 3'b010, 2'b01});
                AWREADY = (aw_n >= s_aw_dly);
                aw_n++;
            end
            if (WVALID) begin
                chk({tag, "_wdata"}, WDATA, d);
                chk({tag, "_wid"}, WID, IW'(g));
                chk({tag, "_w_const"}, {WSTRB, WLAST}, {4'hF, 1'b1});
                WREADY = (w_n >= s_w_dly);
                w_n++;
            end
            if (BREADY) begin
                chk({tag, "_bready_after_aw_w"}, {AWVALID, WVALID}, 0);
                if (b_n >= s_b_dly) begin
                    BVALID = 1'b1; BID = rid; BRESP = s_resp;
                end
                b_n++;
            end
            if (ARVALID) begin
                chk({tag, "_araddr"}, ARADDR, a);
                chk({tag, "_arid"}, ARID, IW'(g));
                ARREADY = (ar_n >= s_ar_dly);
                ar_n++;
            end
            if (RREADY) begin
                if (r_n >= s_r_dly) begin
                    RVALID = 1'b1; RID = rid; RDATA = s_rdata; RRESP = s_resp; RLAST = 1'b1;
                end
                r_n++;
            end
            if (rsp_valid) begin
                done = 1'b1;
                got = {rsp_idx, rsp_rdata, rsp_resp, rsp_id_err};
                chk({tag, "_latency"}, cyc, exp_lat);
                chk({tag, "_q_nonempty"}, exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk({tag, "_rsp"}, got, e);
                end
            end
        end
        chk({tag, "_rsp_seen"}, done, 1);
        if (w) begin
            chk({tag, "_aw_cycles"}, aw_n, s_aw_dly + 1);
            chk({tag, "_w_cycles"}, w_n, s_w_dly + 1);
            chk({tag, "_b_cycles"}, b_n, s_b_dly + 1);
        end else begin
            chk({tag, "_ar_cycles"}, ar_n, s_ar_dly + 1);
            chk({tag, "_r_cycles"}, r_n, s_r_dly + 1);
        end
        slave_quiet();
        step();
        chk({tag, "_rsp_one_cycle"}, rsp_valid, 0);
    endtask

    // Directed sequence, then random traffic, then reset abort
    initial begin
        slave_defaults();
        RESETn = 1'b0;
        repeat (3) step();
        chk("rst_ready", req_ready, 0);
        chk("rst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, rsp_id_err}, 0);
        chk("rst_payload", {AWADDR, ARADDR, WDATA, AWID, ARID, WID}, 0);
        chk("rst_rsp", {rsp_idx, rsp_rdata, rsp_resp}, 0);
        RESETn = 1'b1;
        step();

        // All requesters valid continuously: grants 0,1,2,3,0
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i[0], 32'h100 * (i + 1), 32'hA000 + i);
        req_valid = 4'hF;
        for (int n = 0; n < 5; n++) serve_one($sformatf("rr%0d", n));

        // Single write from requester 1
        req_valid = 4'b0010;
        set_req(1, 1'b1, 32'h1000_0040, 32'hDEAD_BEEF);
        serve_one("wr1");

        // Pointer now 2, only 0 and 3 valid: grants 3 then 0
        req_valid = 4'b1001;
        set_req(0, 1'b0, 32'h0000_0010, 32'h0);
        set_req(3, 1'b1, 32'h0000_0030, 32'h3333_3333);
        s_rdata = 32'hCAFE_0000;
        serve_one("ptr2_a");
        serve_one("ptr2_b");

        // Read from requester 2 with ARREADY delayed
        slave_defaults();
        req_valid = 4'b0100;
        set_req(2, 1'b0, 32'h0000_0020, 32'h0);
        s_ar_dly = 2;
        s_rdata = 32'h1234_5678;
        serve_one("rd2");

        // Write with AWREADY immediate and WREADY late
        slave_defaults();
        req_valid = 4'b1000;
        set_req(3, 1'b1, 32'h0000_0300, 32'h5A5A_A5A5);
        s_w_dly = 3;
        serve_one("wr_split");

        // Error response with mismatched BID on an ID-0 write
        slave_defaults();
        req_valid = 4'b0001;
        set_req(0, 1'b1, 32'h0000_0400, 32'h0BAD_F00D);
        s_resp = 2'b10;
        s_id_ovr = 1'b1;
        s_id_val = 4'd5;
        serve_one("err_bid");

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = '0;
                #1;
                chk("rand_idle_ready", req_ready, 0);
                step();
            end
            for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
            req_valid = 4'($urandom_range(1, 15));
            s_aw_dly = $urandom_range(0, 3);
            s_w_dly  = $urandom_range(0, 3);
            s_ar_dly = $urandom_range(0, 3);
            s_b_dly  = $urandom_range(0, 3);
            s_r_dly  = $urandom_range(0, 3);
            s_resp   = 2'($urandom_range(0, 3));
            s_rdata  = $urandom;
            s_id_ovr = ($urandom_range(0, 5) == 0);
            s_id_val = 4'($urandom_range(0, 15));
            serve_one($sformatf("rand%0d", n));
        end

        // Reset while waiting for R: transaction dropped, pointer back to 0
        slave_defaults();
        req_valid = 4'b0100;
        set_req(2, 1'b0, 32'h0000_0500, 32'h0);
        #1;
        chk("abort_req_ready", req_ready, 64'(1) << model_grant(req_valid, model_ptr));
        step();
        chk("abort_arvalid", ARVALID, 1);
        ARREADY = 1'b1;
        req_valid = '0;
        step();
        ARREADY = 1'b0;
        chk("abort_rready", RREADY, 1);
        RESETn = 1'b0;
        step();
        chk("abort_quiet", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, req_ready}, 0);
        RESETn = 1'b1;
        model_ptr = 0;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("abort_no_rsp", rsp_valid, 0);
        end
        req_valid = 4'b1001;
        set_req(0, 1'b1, 32'h0000_0600, 32'h6666_0000);
        set_req(3, 1'b1, 32'h0000_0630, 32'h6666_0003);
        serve_one("post_rst");

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
